// File: rtl/uart_cmd_responder_if.sv
// Byte-stream and register-bus signals of uart_cmd_responder.
// slave is the responder's side; master is the environment (UART core, register file).
interface uart_cmd_responder_if;
    logic       rx_data_valid_i;
    logic [7:0] rx_data_i;
    logic       tx_data_ready_i;
    logic       tx_data_valid_o;
    logic [7:0] tx_data_o;
    logic       reg_req_o;
    logic       reg_we_o;
    logic [7:0] reg_addr_o;
    logic [7:0] reg_wdata_o;
    logic       reg_ack_i;
    logic [7:0] reg_rdata_i;
    logic       err_o;

    modport slave (
        input  rx_data_valid_i, rx_data_i, tx_data_ready_i, reg_ack_i, reg_rdata_i,
        output tx_data_valid_o, tx_data_o, reg_req_o, reg_we_o, reg_addr_o, reg_wdata_o, err_o
    );

    modport master (
        output rx_data_valid_i, rx_data_i, tx_data_ready_i, reg_ack_i, reg_rdata_i,
        input  tx_data_valid_o, tx_data_o, reg_req_o, reg_we_o, reg_addr_o, reg_wdata_o, err_o
    );
endinterface

// File: rtl/uart_cmd_responder.sv
// Decodes 'R' addr / 'W' addr data frames from a UART byte stream into register accesses and
// replies with read data, ACK or NAK. Define UART_CMD_RESP_CHECKSUM_EN for XOR frame checksums.
module uart_cmd_responder #(
    parameter int unsigned TIMEOUT_CLKS = 100000
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    uart_cmd_responder_if.slave uart_io
);
    localparam int unsigned       TimerW    = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CLKS - 1);
    localparam logic [TimerW-1:0] TimerOne  = TimerW'(1);
    localparam logic [7:0]        CmdRead   = 8'h52;
    localparam logic [7:0]        CmdWrite  = 8'h57;
    localparam logic [7:0]        RespAck   = 8'h06;
    localparam logic [7:0]        RespNak   = 8'h15;

`ifdef UART_CMD_RESP_CHECKSUM_EN
    typedef enum logic [2:0] {
        StIdle, StAddr, StData, StCsum, StBus, StResp, StRespCsum
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle, StAddr, StData, StBus, StResp
    } state_e;
`endif

    state_e            state_q, state_d, frame_done;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [7:0]        addr_q, addr_d, wdata_q, wdata_d, resp_q, resp_d;
    logic              we_q, we_d, err_q, err_d;
    logic              rx_valid, timeout;
    logic [7:0]        rx_data;
`ifdef UART_CMD_RESP_CHECKSUM_EN
    logic [7:0]        cmd_q, cmd_d, csum_q, csum_d;
`endif

    assign rx_valid = uart_io.rx_data_valid_i;
    assign rx_data  = uart_io.rx_data_i;
    // Timer holds the number of idle cycles already spent waiting for the next frame byte.
    assign timeout  = (timer_q == TimerLast);

    always_comb begin
        state_d = state_q;
        timer_d = '0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        resp_d  = resp_q;
        we_d    = we_q;
        err_d   = 1'b0;
`ifdef UART_CMD_RESP_CHECKSUM_EN
        cmd_d      = cmd_q;
        csum_d     = csum_q;
        frame_done = StCsum;
`else
        frame_done = StBus;
`endif
        unique case (state_q)
            StIdle: begin
                if (rx_valid) begin
`ifdef UART_CMD_RESP_CHECKSUM_EN
                    cmd_d  = rx_data;
                    csum_d = rx_data;
`endif
                    if (rx_data == CmdRead || rx_data == CmdWrite) begin
                        we_d    = (rx_data == CmdWrite);
                        state_d = StAddr;
                    end else begin
                        resp_d  = RespNak;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StAddr: begin
                // A byte arriving on the timeout cycle is discarded with the frame.
                if (timeout) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else if (rx_valid) begin
                    addr_d  = rx_data;
`ifdef UART_CMD_RESP_CHECKSUM_EN
                    csum_d  = csum_q ^ rx_data;
`endif
                    state_d = we_q ? StData : frame_done;
                end else begin
                    timer_d = timer_q + TimerOne;
                end
            end
            StData: begin
                if (timeout) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else if (rx_valid) begin
                    wdata_d = rx_data;
`ifdef UART_CMD_RESP_CHECKSUM_EN
                    csum_d  = csum_q ^ rx_data;
`endif
                    state_d = frame_done;
                end else begin
                    timer_d = timer_q + TimerOne;
                end
            end
`ifdef UART_CMD_RESP_CHECKSUM_EN
            StCsum: begin
                if (timeout) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else if (rx_valid) begin
                    if (rx_data == csum_q) begin
                        state_d = StBus;
                    end else begin
                        resp_d  = RespNak;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end
                end else begin
                    timer_d = timer_q + TimerOne;
                end
            end
`endif
            StBus: begin
                err_d = rx_valid;
                if (uart_io.reg_ack_i) begin
                    resp_d  = we_q ? RespAck : uart_io.reg_rdata_i;
                    state_d = StResp;
                end
            end
            StResp: begin
                err_d = rx_valid;
                if (uart_io.tx_data_ready_i) begin
`ifdef UART_CMD_RESP_CHECKSUM_EN
                    state_d = StRespCsum;
`else
                    state_d = StIdle;
`endif
                end
            end
`ifdef UART_CMD_RESP_CHECKSUM_EN
            StRespCsum: begin
                err_d = rx_valid;
                if (uart_io.tx_data_ready_i) begin
                    state_d = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            timer_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            resp_q  <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
`ifdef UART_CMD_RESP_CHECKSUM_EN
            cmd_q   <= '0;
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            resp_q  <= resp_d;
            we_q    <= we_d;
            err_q   <= err_d;
`ifdef UART_CMD_RESP_CHECKSUM_EN
            cmd_q   <= cmd_d;
            csum_q  <= csum_d;
`endif
        end
    end

    assign uart_io.reg_req_o   = (state_q == StBus);
    assign uart_io.reg_we_o    = we_q;
    assign uart_io.reg_addr_o  = addr_q;
    assign uart_io.reg_wdata_o = wdata_q;
    assign uart_io.err_o       = err_q;
`ifdef UART_CMD_RESP_CHECKSUM_EN
    assign uart_io.tx_data_valid_o = (state_q == StResp) || (state_q == StRespCsum);
    assign uart_io.tx_data_o       = (state_q == StRespCsum) ? (cmd_q ^ resp_q) : resp_q;
`else
    assign uart_io.tx_data_valid_o = (state_q == StResp);
    assign uart_io.tx_data_o       = resp_q;
`endif
endmodule
